// File: rtl/ext_obi_cut.sv
// ext_obi_cut: registered OBI cut between the external bus slave port and the
// CGRA slave port. A one-entry request register breaks the request/grant path.
// A response FIFO buffers returning read data. An outstanding counter throttles
// upstream grants so that every accepted transaction always has a FIFO slot for
// its response.
module ext_obi_cut #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // upstream (slave) side
  input  logic                    slv_req_i,
  output logic                    slv_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   slv_addr_i,
  input  logic                    slv_we_i,
  input  logic [DATA_WIDTH/8-1:0] slv_be_i,
  input  logic [DATA_WIDTH-1:0]   slv_wdata_i,
  output logic                    slv_rvalid_o,
  output logic [DATA_WIDTH-1:0]   slv_rdata_o,
  // downstream (master) side
  output logic                    mst_req_o,
  input  logic                    mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mst_addr_o,
  output logic                    mst_we_o,
  output logic [DATA_WIDTH/8-1:0] mst_be_o,
  output logic [DATA_WIDTH-1:0]   mst_wdata_o,
  input  logic                    mst_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mst_rdata_i,
  // status
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } req_state_e;

  req_state_e state_q, state_d;

  // request register payload
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  we_p1;
  logic [BE_W-1:0]       be_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  // handshake and bookkeeping
  logic             can_pop;
  logic             gnt_int;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] dcnt_q;
  logic             dcnt_nz;
  logic             err_q;

  // response FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      fill_q;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  rsp_err;

  // Pointer advance with wrap at the last FIFO slot (depth need not be 2^n).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Request register state: holds at most one transaction awaiting downstream grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, accept and next state. Grant never looks at slv_req_i; the cap on
  // cnt_q uses the registered value only, so a response leaving this cycle
  // does not reopen the grant until the next cycle.
  always_comb begin
    can_pop = 1'b0;
    gnt_int = 1'b0;
    accept  = 1'b0;
    state_d = state_q;
    can_pop = (state_q == FULL) & mst_gnt_i;
    gnt_int = ((state_q == EMPTY) | can_pop) & (cnt_q < MAX_CNT);
    accept  = slv_req_i & gnt_int;
    if (accept) begin
      state_d = FULL;
    end else if (can_pop) begin
      state_d = EMPTY;
    end
  end

  // Grant is held low for the whole reset pulse, not only after the state clears.
  assign slv_gnt_o = gnt_int & ~rst_i;

  // ---- stage p1: request register payload, loaded on every upstream accept ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_p1  <= '0;
      we_p1    <= 1'b0;
      be_p1    <= '0;
      wdata_p1 <= '0;
    end else if (accept) begin
      addr_p1  <= slv_addr_i;
      we_p1    <= slv_we_i;
      be_p1    <= slv_be_i;
      wdata_p1 <= slv_wdata_i;
    end
  end

  assign mst_req_o   = (state_q == FULL);
  assign mst_addr_o  = addr_p1;
  assign mst_we_o    = we_p1;
  assign mst_be_o    = be_p1;
  assign mst_wdata_o = wdata_p1;

  // Upstream outstanding count: accepted upstream, response not yet returned upstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept && !pop) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (!accept && pop) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Downstream outstanding count: granted downstream, response not yet seen.
  // A response that arrives with this count at zero is spurious.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dcnt_q <= '0;
    end else if (can_pop && !(mst_rvalid_i && dcnt_nz)) begin
      dcnt_q <= dcnt_q + 1'b1;
    end else if (!can_pop && mst_rvalid_i && dcnt_nz) begin
      dcnt_q <= dcnt_q - 1'b1;
    end
  end

  assign dcnt_nz    = (dcnt_q != '0);
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == MAX_CNT);
  assign rsp_err    = mst_rvalid_i & (~dcnt_nz | fifo_full);
  assign push       = mst_rvalid_i & dcnt_nz & ~fifo_full;
  assign pop        = ~fifo_empty;

  // FIFO storage; contents are only meaningful between write and read pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mst_rdata_i;
    end
  end

  // ---- stage p2: response FIFO control, drained every cycle it holds data ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        fill_q <= fill_q + 1'b1;
      end else if (!push && pop) begin
        fill_q <= fill_q - 1'b1;
      end
    end
  end

  assign slv_rvalid_o = ~fifo_empty;
  assign slv_rdata_o  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

  // Sticky protocol error: spurious response or response into a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (rsp_err) begin
      err_q <= 1'b1;
    end
  end

  assign err_o  = err_q;
  assign busy_o = (cnt_q != '0) | mst_req_o;

endmodule

// File: tb/tb_ext_obi_cut.sv
// Testbench for ext_obi_cut: a MAX_OUTSTANDING=4 instance driven from a vector
// table with a queue scoreboard and a reactive downstream slave, plus a
// MAX_OUTSTANDING=2 instance exercised by a hand-written limit sequence.
module tb_ext_obi_cut;

  logic clk;
  logic rst_i;

  // main instance (MAX_OUTSTANDING = 4)
  logic        slv_req_i, slv_gnt_o, slv_we_i, slv_rvalid_o;
  logic [31:0] slv_addr_i, slv_wdata_i, slv_rdata_o;
  logic [3:0]  slv_be_i;
  logic        mst_req_o, mst_gnt_i, mst_we_o, mst_rvalid_i;
  logic [31:0] mst_addr_o, mst_wdata_o, mst_rdata_i;
  logic [3:0]  mst_be_o;
  logic        busy_o, err_o;

  // limit instance (MAX_OUTSTANDING = 2)
  logic        b_req, b_slv_gnt, b_slv_rvalid;
  logic [31:0] b_addr, b_slv_rdata;
  logic        b_mst_req, b_gnt, b_mst_we, b_rvalid;
  logic [31:0] b_mst_addr, b_mst_wdata, b_rdata;
  logic [3:0]  b_mst_be;
  logic        b_busy, b_err;

  ext_obi_cut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .slv_req_i(slv_req_i), .slv_gnt_o(slv_gnt_o), .slv_addr_i(slv_addr_i),
    .slv_we_i(slv_we_i), .slv_be_i(slv_be_i), .slv_wdata_i(slv_wdata_i),
    .slv_rvalid_o(slv_rvalid_o), .slv_rdata_o(slv_rdata_o),
    .mst_req_o(mst_req_o), .mst_gnt_i(mst_gnt_i), .mst_addr_o(mst_addr_o),
    .mst_we_o(mst_we_o), .mst_be_o(mst_be_o), .mst_wdata_o(mst_wdata_o),
    .mst_rvalid_i(mst_rvalid_i), .mst_rdata_i(mst_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  ext_obi_cut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i),
    .slv_req_i(b_req), .slv_gnt_o(b_slv_gnt), .slv_addr_i(b_addr),
    .slv_we_i(1'b0), .slv_be_i(4'hF), .slv_wdata_i(32'h0),
    .slv_rvalid_o(b_slv_rvalid), .slv_rdata_o(b_slv_rdata),
    .mst_req_o(b_mst_req), .mst_gnt_i(b_gnt), .mst_addr_o(b_mst_addr),
    .mst_we_o(b_mst_we), .mst_be_o(b_mst_be), .mst_wdata_o(b_mst_wdata),
    .mst_rvalid_i(b_rvalid), .mst_rdata_i(b_rdata),
    .busy_o(b_busy), .err_o(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  vec_t        vecs [8];
  req_t        req_q [$];
  logic [31:0] rsp_q [$];
  logic [31:0] pend  [$];

  int   tests = 0;
  int   fails = 0;
  int   n_rsp = 0;
  logic withhold = 1'b0;
  logic spur     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d);
    slv_req_i   = 1'b1;
    slv_addr_i  = a;
    slv_we_i    = w;
    slv_be_i    = b;
    slv_wdata_i = d;
  endtask

  // Called at a negedge: record expectations for a handshake happening this cycle.
  task automatic note_accept(input logic [31:0] exp_rd);
    req_t r;
    if (slv_req_i && slv_gnt_o) begin
      r.addr  = slv_addr_i;
      r.we    = slv_we_i;
      r.be    = slv_be_i;
      r.wdata = slv_wdata_i;
      req_q.push_back(r);
      rsp_q.push_back(exp_rd);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_o || slv_rvalid_o || rsp_q.size() != 0 || pend.size() != 0) && n < 60);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    check({name, "_rspq"}, 32'(rsp_q.size()), 32'd0);
  endtask

  // Downstream slave: responds one cycle after each grant with addr + 0x1000.
  initial begin
    mst_rvalid_i = 1'b0;
    mst_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst_i && mst_req_o && mst_gnt_i) pend.push_back(mst_addr_o + 32'h1000);
      @(posedge clk);
      #2;
      if (spur) begin
        mst_rvalid_i = 1'b1;
        mst_rdata_i  = 32'hBAD0BAD0;
        spur         = 1'b0;
      end else if (!withhold && pend.size() > 0) begin
        mst_rvalid_i = 1'b1;
        mst_rdata_i  = pend.pop_front();
      end else begin
        mst_rvalid_i = 1'b0;
        mst_rdata_i  = '0;
      end
    end
  end

  // Scoreboard: downstream handshakes and upstream responses against the queues.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (mst_req_o && mst_gnt_i) begin
        if (req_q.size() == 0) begin
          check("unexpected_mst_req", 32'(req_q.size()), 32'd1);
        end else begin
          req_t e;
          e = req_q.pop_front();
          check("mst_addr", mst_addr_o, e.addr);
          check("mst_we", 32'(mst_we_o), 32'(e.we));
          check("mst_be", 32'(mst_be_o), 32'(e.be));
          check("mst_wdata", mst_wdata_o, e.wdata);
        end
      end
      if (slv_rvalid_o) begin
        n_rsp++;
        if (rsp_q.size() == 0) begin
          check("unexpected_slv_rvalid", 32'(rsp_q.size()), 32'd1);
        end else begin
          check("slv_rdata", slv_rdata_o, rsp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int acc;
    vecs[0] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0, 32'h0000_1000};
    vecs[1] = '{32'h0000_0004, 1'b0, 4'hF, 32'h0, 32'h0000_1004};
    vecs[2] = '{32'h0000_0008, 1'b0, 4'hF, 32'h0, 32'h0000_1008};
    vecs[3] = '{32'h0000_000C, 1'b0, 4'hF, 32'h0, 32'h0000_100C};
    vecs[4] = '{32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h0000_1010};
    vecs[5] = '{32'h0000_0014, 1'b0, 4'hF, 32'h0, 32'h0000_1014};
    vecs[6] = '{32'h0000_0018, 1'b0, 4'hF, 32'h0, 32'h0000_1018};
    vecs[7] = '{32'h0000_001C, 1'b0, 4'hF, 32'h0, 32'h0000_101C};

    rst_i = 1'b1;
    slv_req_i = 1'b0; slv_addr_i = '0; slv_we_i = 1'b0; slv_be_i = '0; slv_wdata_i = '0;
    mst_gnt_i = 1'b1;
    b_req = 1'b0; b_addr = '0; b_gnt = 1'b1; b_rvalid = 1'b0; b_rdata = '0;

    // reset state
    @(negedge clk);
    check("rst_mst_req", 32'(mst_req_o), 32'd0);
    check("rst_slv_gnt", 32'(slv_gnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_slv_rvalid", 32'(slv_rvalid_o), 32'd0);
    check("rst_b_slv_gnt", 32'(b_slv_gnt), 32'd0);
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_mst_addr", mst_addr_o, 32'd0);
    check("post_rst_slv_rdata", slv_rdata_o, 32'd0);
    check("post_rst_slv_gnt", 32'(slv_gnt_o), 32'd1);

    // outstanding limit on the MAX_OUTSTANDING=2 instance
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      b_req    = (c < 8);
      b_addr   = 32'h200 + 32'(4 * (c < 2 ? c : 2));
      b_rvalid = (c == 5);
      b_rdata  = (c == 5) ? 32'h5A5A_0001 : 32'h0;
      @(negedge clk);
      if (c == 1) check("lim_mst_addr_c1", b_mst_addr, 32'h200);
      if (c == 6) begin
        check("lim_accepts", 32'(acc), 32'd2);
        check("lim_rvalid", 32'(b_slv_rvalid), 32'd1);
        check("lim_rdata", b_slv_rdata, 32'h5A5A_0001);
      end
      check($sformatf("lim_gnt_c%0d", c), 32'(b_slv_gnt), (c < 2 || c == 7) ? 32'd1 : 32'd0);
      if (b_req && b_slv_gnt) acc++;
    end
    step();
    b_req = 1'b0;
    b_rvalid = 1'b0;
    @(negedge clk);
    check("lim_err", 32'(b_err), 32'd0);

    // single write
    step();
    drive_req(32'h0000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_gnt", 32'(slv_gnt_o), 32'd1);
    note_accept(32'h0000_1100);
    step();
    slv_req_i = 1'b0;
    @(negedge clk);
    check("wr_mst_req", 32'(mst_req_o), 32'd1);
    step();
    @(negedge clk);
    check("wr_no_early_rvalid", 32'(slv_rvalid_o), 32'd0);
    step();
    @(negedge clk);
    check("wr_slv_rvalid", 32'(slv_rvalid_o), 32'd1);
    step();
    @(negedge clk);
    check("wr_busy_clear", 32'(busy_o), 32'd0);

    // back-to-back reads from the vector table
    base = n_rsp;
    for (int i = 0; i < 8; i++) begin
      step();
      drive_req(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("b2b_gnt%0d", i), 32'(slv_gnt_o), 32'd1);
      note_accept(vecs[i].exp_rdata);
    end
    step();
    slv_req_i = 1'b0;
    wait_idle("b2b");
    check("b2b_rsp_count", 32'(n_rsp - base), 32'd8);

    // downstream stall
    step();
    mst_gnt_i = 1'b0;
    drive_req(32'h0000_0300, 1'b1, 4'h3, 32'h1234_5678);
    @(negedge clk);
    note_accept(32'h0000_1300);
    for (int s = 1; s <= 5; s++) begin
      step();
      drive_req(32'h0000_0304, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      check($sformatf("stall_gnt%0d", s), 32'(slv_gnt_o), 32'd0);
      check($sformatf("stall_req%0d", s), 32'(mst_req_o), 32'd1);
      check($sformatf("stall_addr%0d", s), mst_addr_o, 32'h0000_0300);
      check($sformatf("stall_wdata%0d", s), mst_wdata_o, 32'h1234_5678);
      check($sformatf("stall_be%0d", s), 32'(mst_be_o), 32'h3);
    end
    step();
    mst_gnt_i = 1'b1;
    @(negedge clk);
    check("stall_release_gnt", 32'(slv_gnt_o), 32'd1);
    note_accept(32'h0000_1304);
    step();
    slv_req_i = 1'b0;
    wait_idle("stall");

    // spurious response
    step();
    spur = 1'b1;
    @(negedge clk);
    check("spur_err_before", 32'(err_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check($sformatf("spur_err%0d", k), 32'(err_o), 32'd1);
      check($sformatf("spur_rvalid%0d", k), 32'(slv_rvalid_o), 32'd0);
    end

    // asynchronous reset with three transactions outstanding
    withhold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      drive_req(32'h80 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      note_accept(32'h1080 + 32'(4 * i));
    end
    step();
    slv_req_i = 1'b0;
    step();
    @(negedge clk);
    check("mid_busy_before", 32'(busy_o), 32'd1);
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_mst_req", 32'(mst_req_o), 32'd0);
    check("arst_slv_rvalid", 32'(slv_rvalid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);
    check("arst_slv_gnt", 32'(slv_gnt_o), 32'd0);
    pend.delete();
    req_q.delete();
    rsp_q.delete();
    withhold = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("rel_busy", 32'(busy_o), 32'd0);
    check("rel_slv_rvalid", 32'(slv_rvalid_o), 32'd0);
    base = n_rsp;
    step();
    drive_req(32'h0000_0040, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("fresh_gnt", 32'(slv_gnt_o), 32'd1);
    note_accept(32'h0000_1040);
    step();
    slv_req_i = 1'b0;
    wait_idle("fresh");
    check("fresh_rsp_count", 32'(n_rsp - base), 32'd1);
    check("fresh_err", 32'(err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
